// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one UART transmitter to N_REQ byte-stream requesters for whole strings.
// Optional idle-owner watchdog: define UART_TX_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module uart_tx_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
`ifdef UART_TX_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       uart_tx_data,
    output logic                    uart_tx_ready,
    input  logic                    uart_tx_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_OWN       = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        busy_cnt_q, busy_cnt_d;

    logic [N_REQ-1:0]  eligible;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  owner_next;
    int                scan_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [N_REQ-1:0]  mask_q, mask_d;

    // A revoked requester stays out of arbitration until it drops its lock once.
    assign eligible = req_lock & ~mask_q;
`else
    assign eligible = req_lock;
`endif

    // Wrap is an explicit compare so non-power-of-two N_REQ stays in range.
    assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_idx = int'(rr_ptr_q) + off;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!win_found && eligible[IDX_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        done_d     = '0;
        ready_d    = 1'b0;
        data_d     = data_q;
        busy_cnt_d = busy_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        mask_d     = mask_q & req_lock;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    owner_d = win_idx;
                    grant_d = ONE << win_idx;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!req_lock[owner_q]) begin
                    grant_d  = '0;
                    rr_ptr_d = owner_next;
                    state_d  = S_IDLE;
                end else if (req_valid[owner_q] && uart_tx_done) begin
                    data_d     = req_data[int'(owner_q)*DATA_W +: DATA_W];
                    ack_d      = ONE << owner_q;
                    ready_d    = 1'b1;
                    busy_cnt_d = '0;
                    state_d    = S_WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (!req_valid[owner_q] && (tmo_cnt_q == TMO_LAST)) begin
                    grant_d         = '0;
                    rr_ptr_d        = owner_next;
                    state_d         = S_IDLE;
                    mask_d[owner_q] = 1'b1;
`endif
                end
            end
            S_WAIT_BUSY: begin
                // A start that the UART never acknowledges is re-issued with the same byte.
                if (!uart_tx_done) begin
                    busy_cnt_d = '0;
                    state_d    = S_WAIT_DONE;
                end else if (busy_cnt_q == 2'd3) begin
                    ready_d    = 1'b1;
                    busy_cnt_d = '0;
                end else begin
                    busy_cnt_d = busy_cnt_q + 2'd1;
                end
            end
            S_WAIT_DONE: begin
                if (uart_tx_done) begin
                    done_d  = ONE << owner_q;
                    state_d = S_OWN;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == S_OWN) && (state_d == S_OWN) && !req_valid[owner_q]) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            busy_cnt_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            mask_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            busy_cnt_q <= busy_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            mask_q     <= mask_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign req_ack       = ack_q;
    assign req_done      = done_q;
    assign uart_tx_ready = ready_q;
    assign uart_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a cycle-exact vector table plus UART-model sequences.
module tb_uart_tx_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req_lock;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic [1:0]  grant;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_tx_done;

    logic        use_model;
    logic        tb_done;
    logic        model_rst;
    logic        model_done;
    int          model_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Monitor state
    logic [7:0]  rdy_log[$];
    int          ack_cnt[2];
    int          done_cnt[2];
    int          ff_cnt;
    int          bad_inv;
    int          low_run;
    int          last_low;

    uart_tx_arbiter #(
        .N_REQ(2),
        .DATA_W(8)
`ifdef UART_TX_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(20)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_lock(req_lock),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ack(req_ack),
        .req_done(req_done),
        .grant(grant),
        .uart_tx_data(uart_tx_data),
        .uart_tx_ready(uart_tx_ready),
        .uart_tx_done(uart_tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign uart_tx_done = use_model ? model_done : tb_done;

    // UART model: a start pulse seen while idle makes it busy for 10 cycles.
    always @(posedge clock) begin
        if (model_rst) begin
            model_done <= 1'b1;
            model_cnt  <= 0;
        end else if (model_done && uart_tx_ready && use_model) begin
            model_done <= 1'b0;
            model_cnt  <= 10;
        end else if (!model_done) begin
            if (model_cnt == 1) model_done <= 1'b1;
            model_cnt <= model_cnt - 1;
        end
    end

    initial begin
        ack_cnt  = '{0, 0};
        done_cnt = '{0, 0};
        ff_cnt   = 0;
        bad_inv  = 0;
        low_run  = 0;
        last_low = 0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (uart_tx_ready) rdy_log.push_back(uart_tx_data);
            for (int i = 0; i < 2; i++) begin
                if (req_ack[i])  ack_cnt[i]++;
                if (req_done[i]) done_cnt[i]++;
            end
            if (uart_tx_data == 8'hFF) ff_cnt++;
            if ((grant & (grant - 2'd1)) != 2'b00) bad_inv++;
            if (((req_ack | req_done) & ~grant) != 2'b00) bad_inv++;
            if (!uart_tx_done) begin
                low_run++;
            end else if (low_run > 0) begin
                last_low = low_run;
                low_run  = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // which: 0 = req_ack[idx], 1 = req_done[idx], 2 = UART busy, 3 = grant[idx]
    task automatic wait_for(input int which, input int idx, input int budget, input string name);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(posedge clock); #1;
            case (which)
                0: hit = req_ack[idx];
                1: hit = req_done[idx];
                2: hit = !uart_tx_done;
                default: hit = grant[idx];
            endcase
        end
        check({name, " reached"}, 32'(hit), 32'd1);
    endtask

    task automatic step;
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [1:0] lock;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       txd;
        logic [1:0] e_grant;
        logic [1:0] e_ack;
        logic [1:0] e_done;
        logic       e_rdy;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int base_rdy;
        int base_ack0;
        int base_done0;
        int base_done1;
        logic stayed;

        // Cycle-exact table, UART done driven directly
        tbl[0]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00};
        tbl[1]  = '{2'b10, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 8'h00};
        tbl[2]  = '{2'b11, 2'b01, 8'hAA, 8'h00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 8'h00};
        tbl[3]  = '{2'b11, 2'b10, 8'hAA, 8'h5C, 1'b1, 2'b10, 2'b10, 2'b00, 1'b1, 8'h5C};
        tbl[4]  = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 8'h5C};
        tbl[5]  = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 8'h5C};
        tbl[6]  = '{2'b01, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 8'h5C};
        tbl[7]  = '{2'b01, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 8'h5C};
        tbl[8]  = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 8'h5C};
        tbl[9]  = '{2'b11, 2'b01, 8'h3C, 8'h00, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 8'h3C};
        tbl[10] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 8'h3C};
        tbl[11] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 8'h3C};
        tbl[12] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 8'h3C};
        tbl[13] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 8'h3C};
        tbl[14] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 8'h3C};
        tbl[15] = '{2'b10, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 8'h3C};
        tbl[16] = '{2'b10, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 8'h3C};
        tbl[17] = '{2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 8'h3C};

        use_model = 1'b0;
        model_rst = 1'b1;
        tb_done   = 1'b1;
        reset     = 1'b1;
        req_lock  = 2'b00;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        repeat (3) step();
        check("reset grant", 32'(grant), 32'd0);
        check("reset data", 32'(uart_tx_data), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req_lock  = tbl[i].lock;
            req_valid = tbl[i].valid;
            req_data  = {tbl[i].d1, tbl[i].d0};
            tb_done   = tbl[i].txd;
            step();
            check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("row%0d ack", i), 32'(req_ack), 32'(tbl[i].e_ack));
            check($sformatf("row%0d done", i), 32'(req_done), 32'(tbl[i].e_done));
            check($sformatf("row%0d ready", i), 32'(uart_tx_ready), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d data", i), 32'(uart_tx_data), 32'(tbl[i].e_data));
        end

        // Reset with both locks held, then switch to the UART model
        req_valid = 2'b00;
        req_lock  = 2'b11;
        reset     = 1'b1;
        model_rst = 1'b0;
        use_model = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d grant", i), 32'(grant), 32'd0);
            check($sformatf("rst%0d strobes", i), 32'({req_ack, req_done, uart_tx_ready}), 32'd0);
        end
        reset = 1'b0;
        step();
        step();
        check("post-reset grant", 32'(grant), 32'd1);

        // Owner 0 sends two bytes while requester 1 offers FF
        base_rdy   = rdy_log.size();
        base_ack0  = ack_cnt[0];
        base_done0 = done_cnt[0];
        req_valid  = 2'b10;
        req_data   = {8'hFF, 8'h48};
        req_valid[0] = 1'b1;
        wait_for(0, 0, 10, "ack 48");
        req_valid[0] = 1'b0;
        wait_for(1, 0, 30, "done 48");
        req_data[7:0] = 8'h69;
        req_valid[0]  = 1'b1;
        wait_for(0, 0, 10, "ack 69");
        req_valid[0] = 1'b0;
        wait_for(1, 0, 30, "done 69");
        step();
        check("two bytes ready count", 32'(rdy_log.size() - base_rdy), 32'd2);
        if (rdy_log.size() >= base_rdy + 2) begin
            check("byte0 data", 32'(rdy_log[base_rdy]), 32'h48);
            check("byte1 data", 32'(rdy_log[base_rdy + 1]), 32'h69);
        end
        check("ack0 count", 32'(ack_cnt[0] - base_ack0), 32'd2);
        check("done0 count", 32'(done_cnt[0] - base_done0), 32'd2);
        check("grant held", 32'(grant), 32'd1);
        check("FF never sent", 32'(ff_cnt), 32'd0);
        check("ack1 for non-owner", 32'(ack_cnt[1]), 32'd1);

        // Lock 0 drops while its byte is in flight
        req_valid     = 2'b00;
        req_data[7:0] = 8'h55;
        req_valid[0]  = 1'b1;
        wait_for(0, 0, 10, "ack 55");
        req_valid[0] = 1'b0;
        wait_for(2, 0, 5, "uart busy 55");
        step();
        req_lock = 2'b10;
        wait_for(1, 0, 30, "done 55");
        check("grant during done", 32'(grant), 32'd1);
        check("byte not truncated", 32'(last_low), 32'd10);
        check("last data 55", 32'(rdy_log[rdy_log.size() - 1]), 32'h55);
        step();
        check("grant released", 32'(grant), 32'd0);
        step();
        check("grant to 1", 32'(grant), 32'd2);

        // Reset while owner 1 waits for the UART
        req_data[15:8] = 8'h7E;
        req_valid[1]   = 1'b1;
        wait_for(0, 1, 10, "ack 7E");
        req_valid[1] = 1'b0;
        wait_for(2, 0, 5, "uart busy 7E");
        step();
        step();
        reset = 1'b1;
        step();
        check("mid-byte reset grant", 32'(grant), 32'd0);
        check("mid-byte reset strobes", 32'({req_ack, req_done, uart_tx_ready}), 32'd0);
        check("mid-byte reset data", 32'(uart_tx_data), 32'd0);
        reset      = 1'b0;
        req_lock   = 2'b00;
        base_done1 = done_cnt[1];
        repeat (15) step();
        check("no done after reset", 32'(done_cnt[1] - base_done1), 32'd0);
        check("idle after reset", 32'(grant), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        req_lock = 2'b01;
        wait_for(3, 0, 5, "timeout grant");
        begin
            int c;
            c = 0;
            while (grant[0] && c < 40) begin
                step();
                c++;
            end
            check("timeout cycles", 32'(c), 32'd20);
        end
        stayed = 1'b1;
        repeat (10) begin
            step();
            if (grant != 2'b00) stayed = 1'b0;
        end
        check("masked until toggle", 32'(stayed), 32'd1);
        req_lock = 2'b00;
        step();
        req_lock = 2'b01;
        wait_for(3, 0, 4, "regrant after toggle");
`else
        stayed = 1'b0;
`endif

        check("grant one-hot and strobes owned", 32'(bad_inv), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between N_REQ byte-stream requesters, such as string senders from ROM and from RAM. It replaces hand-built select muxes and per-state select registers in a top-level FSM. A requester locks the transmitter for a whole string and receives the grant under round-robin fairness. The block then sequences each byte through the UART handshake and returns per-byte accept and done strobes.

Parameters:
N_REQ, 2, number of requesters; legal values 2..4.
DATA_W, 8, byte width.
TIMEOUT_CYCLES, 65535, idle-owner watchdog limit; used only when the optional feature is compiled in.

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
req_lock  in  N_REQ  requester i wants ownership of the UART for a string
req_valid  in  N_REQ  requester i presents a byte on its data slice
req_data  in  N_REQ*DATA_W  byte of requester i in slice [i*DATA_W +: DATA_W]
req_ack  out  N_REQ  one-cycle pulse: byte of requester i latched
req_done  out  N_REQ  one-cycle pulse: byte of requester i fully transmitted
grant  out  N_REQ  one-hot current owner; all zero when no owner
uart_tx_data  out  DATA_W  byte to the UART, held stable through the transfer
uart_tx_ready  out  1  one-cycle start pulse to the UART
uart_tx_done  in  1  UART idle level: 1 = idle, 0 = shifting

Behaviour:
- Reset values (synchronous, when reset=1 at a clock edge): state=IDLE, grant=0, req_ack=0, req_done=0, uart_tx_ready=0, uart_tx_data=0, rr_ptr=0. Reset overrides everything, including a byte in flight. The UART is reset separately.
- All outputs are registered.
- IDLE state:
  - Scan req_lock starting at rr_ptr, wrapping modulo N_REQ. The first requester found is the winner.
  - Set grant to the winner's one-hot value on the next edge and move to OWN.
  - If no lock is asserted, stay in IDLE with grant=0.
- OWN state (owner is k):
  - If req_lock[k]=0, clear grant, set rr_ptr=(k+1) mod N_REQ, go to IDLE. The next grant is possible one cycle later, so the lock-to-grant latency is 2 cycles minimum.
  - Else if req_valid[k]=1 and uart_tx_done=1: latch req_data slice k into uart_tx_data, pulse req_ack[k] and uart_tx_ready together for one cycle, go to WAIT_BUSY.
  - req_valid of non-owners is ignored.
  - Lock and valid asserted together while owning: the byte is sent and the lock is honoured.
- WAIT_BUSY state:
  - Wait for uart_tx_done=0, then go to WAIT_DONE.
  - If uart_tx_done stays 1 for 4 cycles, treat the start as lost: re-pulse uart_tx_ready with the same data and restart the 4-cycle count. This does not produce another req_ack.
- WAIT_DONE state:
  - When uart_tx_done=1, pulse req_done[k] for one cycle and return to OWN.
  - Grant is held throughout, even if req_lock[k] drops mid-byte. The release takes effect in OWN after done.
- The requester must hold req_data stable only until req_ack. It may present the next byte immediately after req_done.
- Fairness: the owner releases, then the search starts at the next index, so with every lock asserted continuously no requester waits more than N_REQ-1 ownerships.
- grant is always zero or one-hot. req_ack and req_done are never asserted for a non-owner.
- Width rule: rr_ptr is $clog2(N_REQ) bits. Wrap uses an explicit compare against N_REQ-1, not natural overflow.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN
- Defined: a 16-bit counter runs in OWN while req_valid[k]=0. It clears on any byte start and on every state exit.
  - When it reaches TIMEOUT_CYCLES, grant is revoked exactly as a lock release (rr_ptr advances, go to IDLE).
  - That requester is then masked from arbitration until it deasserts req_lock for at least one cycle.
- Undefined: no counter. The owner keeps the grant indefinitely while req_lock is held.

Test Plan:
- Reset with req_lock=2'b11 held, release reset -> grant=2'b01 two edges later; all strobes 0 during reset.
- Owner 0 sends 8'h48 then 8'h69 against a UART model with a 10-cycle busy time -> exactly 2 uart_tx_ready pulses with data 48,69; req_ack[0] and req_done[0] each pulse twice; grant stays 01.
- Both locks held, 0 releases after one byte -> grant 01 -> 00 -> 10; then with 1 released and both re-locked, grant=01 (round-robin).
- req_valid[1]=1 with data 8'hFF while owner is 0 -> uart_tx_data never shows FF; req_ack[1] stays 0.
- req_lock[0] drops during WAIT_DONE -> req_done[0] still pulses, then grant=00; the byte completes and is not truncated.
- Reset asserted in WAIT_DONE -> next cycle state=IDLE, grant=0, no req_done. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20: owner locks with no valid -> grant drops at cycle 20 and is not re-granted until the lock toggles.
